// File: rtl/rtc_bus_scheduler.sv
// Multiplexed-bus sequencer for the external RTC: arbitrates the user write port against the per-frame refresh reader.
// Define RTC_SCHED_STATS_EN to add the saturating drop_cnt output for discarded frame ticks.
module rtc_bus_scheduler #(
  parameter int PHASE_CYC = 8,
  parameter int GAP_CYC   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        frame_tick,
  input  logic        wr_req,
  input  logic [7:0]  wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_done,
  input  logic [7:0]  bus_in,
  output logic [7:0]  bus_out,
  output logic        bus_oe,
  output logic        cs_n,
  output logic        a_d_n,
  output logic        rd_n,
  output logic        wr_n,
  output logic [47:0] clk_regs,
  output logic [23:0] tmr_regs,
  output logic        data_valid,
  output logic        busy
`ifdef RTC_SCHED_STATS_EN
  ,
  output logic [15:0] drop_cnt
`endif
);

  localparam int CMAX = (PHASE_CYC > GAP_CYC) ? PHASE_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] PH_LAST  = CW'(PHASE_CYC - 1);
  localparam logic [CW-1:0] PH_SMP   = CW'(PHASE_CYC - 2);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, GAP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [7:0]    addr_q, addr_d, data_q, data_d;
  logic          ref_q, ref_d;
  logic [3:0]    idx_q, idx_d;
  logic          wr_blk_q;
  logic [7:0]    shadow_q [9];
  logic          commit, sample, drv, strb;

  logic          cs_n_q, cs_n_d, a_d_n_q, a_d_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d;
  logic          oe_q, oe_d, wr_done_q, wr_done_d, dv_q, busy_q, busy_d;
  logic [7:0]    bus_out_q, bus_out_d;
  logic [47:0]   clk_regs_q;
  logic [23:0]   tmr_regs_q;

  function automatic logic [7:0] ref_addr(input logic [3:0] i);
    case (i)
      4'd0:    ref_addr = 8'h21;
      4'd1:    ref_addr = 8'h22;
      4'd2:    ref_addr = 8'h23;
      4'd3:    ref_addr = 8'h24;
      4'd4:    ref_addr = 8'h25;
      4'd5:    ref_addr = 8'h26;
      4'd6:    ref_addr = 8'h43;
      4'd7:    ref_addr = 8'h42;
      default: ref_addr = 8'h41;
    endcase
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    idx_d   = idx_q;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // wr_blk_q masks the stale wr_req in the cycle right after wr_done
        if (wr_req && !wr_blk_q) begin
          state_d = ADDR;
          is_wr_d = 1'b1;
          addr_d  = wr_addr;
          data_d  = wr_data;
        end else if (ref_q) begin
          state_d = ADDR;
          is_wr_d = 1'b0;
          addr_d  = ref_addr(idx_q);
        end
      end
      ADDR: if (cnt_q == PH_LAST) begin state_d = DATA; cnt_d = '0; end
      DATA: if (cnt_q == PH_LAST) begin state_d = GAP;  cnt_d = '0; end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (!is_wr_q) begin
            if (idx_q == 4'd8) begin
              commit = 1'b1;
              idx_d  = 4'd0;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    ref_d  = commit ? 1'b0 : (ref_q | frame_tick);
    sample = (state_q == DATA) && !is_wr_q && (cnt_q == PH_SMP);

    // Outputs are derived from the next state so the registered pins line up with the FSM state
    drv       = (state_d == ADDR) || ((state_d == DATA) && is_wr_d);
    strb      = (cnt_d != PH_LAST);
    cs_n_d    = !((state_d == ADDR) || (state_d == DATA));
    a_d_n_d   = (state_d != ADDR);
    oe_d      = drv;
    bus_out_d = (state_d == ADDR) ? addr_d : (drv ? data_d : 8'h00);
    wr_n_d    = !(drv && strb);
    rd_n_d    = !((state_d == DATA) && !is_wr_d && strb);
    wr_done_d = (state_d == GAP) && (cnt_d == '0) && is_wr_d;
    busy_d    = (state_d != IDLE) || ref_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      addr_q     <= 8'h00;
      data_q     <= 8'h00;
      ref_q      <= 1'b0;
      idx_q      <= 4'd0;
      wr_blk_q   <= 1'b0;
      cs_n_q     <= 1'b1;
      a_d_n_q    <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      oe_q       <= 1'b0;
      bus_out_q  <= 8'h00;
      wr_done_q  <= 1'b0;
      dv_q       <= 1'b0;
      busy_q     <= 1'b0;
      clk_regs_q <= 48'h0;
      tmr_regs_q <= 24'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      ref_q     <= ref_d;
      idx_q     <= idx_d;
      wr_blk_q  <= wr_done_q;
      cs_n_q    <= cs_n_d;
      a_d_n_q   <= a_d_n_d;
      rd_n_q    <= rd_n_d;
      wr_n_q    <= wr_n_d;
      oe_q      <= oe_d;
      bus_out_q <= bus_out_d;
      wr_done_q <= wr_done_d;
      dv_q      <= commit;
      busy_q    <= busy_d;
      if (commit) begin
        clk_regs_q <= {shadow_q[5], shadow_q[4], shadow_q[3], shadow_q[2], shadow_q[1], shadow_q[0]};
        tmr_regs_q <= {shadow_q[8], shadow_q[7], shadow_q[6]};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sample) shadow_q[idx_q] <= bus_in;
  end

`ifdef RTC_SCHED_STATS_EN
  logic [15:0] drop_q;
  always_ff @(posedge clk) begin
    if (reset) drop_q <= 16'h0;
    else if (frame_tick && ref_q && (drop_q != 16'hFFFF)) drop_q <= drop_q + 16'h1;
  end
  assign drop_cnt = drop_q;
`endif

  assign cs_n       = cs_n_q;
  assign a_d_n      = a_d_n_q;
  assign rd_n       = rd_n_q;
  assign wr_n       = wr_n_q;
  assign bus_oe     = oe_q;
  assign bus_out    = bus_out_q;
  assign wr_done    = wr_done_q;
  assign data_valid = dv_q;
  assign busy       = busy_q;
  assign clk_regs   = clk_regs_q;
  assign tmr_regs   = tmr_regs_q;

endmodule
